// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: instruction codes, register sentinel,
// hazard-controller state encoding and the per-stage control bundle.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] HS_RUN      = 2'd0;
  localparam logic [1:0] HS_RET_WAIT = 2'd1;
  localparam logic [1:0] HS_HALTED   = 2'd2;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic halted;
  } haz_ctrl_t;

  localparam haz_ctrl_t CTRL_NONE     = haz_ctrl_t'(5'b00000);
  localparam haz_ctrl_t CTRL_LOAD_USE = haz_ctrl_t'(5'b11010);
  localparam haz_ctrl_t CTRL_MISPRED  = haz_ctrl_t'(5'b00110);
  localparam haz_ctrl_t CTRL_RET      = haz_ctrl_t'(5'b10100);
  localparam haz_ctrl_t CTRL_HALT     = haz_ctrl_t'(5'b11011);

  // Instructions whose execute-stage result only exists after the memory read.
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == ICODE_MRMOVL) || (icode == ICODE_POPL);
  endfunction

endpackage

// File: rtl/haz_sat_counter.sv
// Saturating event counter: increments on each cycle with inc=1, sticks at
// all-ones, clears on synchronous reset.
module haz_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard control: registered stall/bubble for fetch/decode/execute.
// Optional HAZ_STATS_EN builds saturating stall/bubble statistics counters.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned RET_BUBBLES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       w_icode,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       dbg_state
);

  localparam int unsigned RC_W = $clog2(RET_BUBBLES + 1);

  logic [1:0]      state_q, state_d;
  logic [RC_W-1:0] cnt_q, cnt_d;
  haz_ctrl_t       ctrl_q, ctrl_d;

  logic load_use;
  logic mispredict;
  logic halt_seen;
  logic ret_seen;

  always_comb begin
    load_use   = is_mem_load(e_icode) && (e_dstM != REG_NONE) &&
                 ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    mispredict = (e_icode == ICODE_JXX) && !e_cnd;
    halt_seen  = (w_icode == ICODE_HALT);
    ret_seen   = (d_icode == ICODE_RET);
  end

  // Priority chain: halt > mispredict > ret drain > load/use > new ret.
  // Load/use is ignored while draining a ret so d_stall never meets d_bubble.
  always_comb begin
    state_d = HS_RUN;
    cnt_d   = '0;
    ctrl_d  = CTRL_NONE;
    if ((state_q == HS_HALTED) || halt_seen) begin
      state_d = HS_HALTED;
      ctrl_d  = CTRL_HALT;
    end else if (mispredict) begin
      ctrl_d = CTRL_MISPRED;
    end else if (state_q == HS_RET_WAIT) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_d != '0) begin
        state_d = HS_RET_WAIT;
        ctrl_d  = CTRL_RET;
      end
    end else if (load_use) begin
      ctrl_d = CTRL_LOAD_USE;
    end else if (ret_seen) begin
      state_d = HS_RET_WAIT;
      cnt_d   = RC_W'(RET_BUBBLES);
      ctrl_d  = CTRL_RET;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HS_RUN;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign f_stall   = ctrl_q.f_stall;
  assign d_stall   = ctrl_q.d_stall;
  assign d_bubble  = ctrl_q.d_bubble;
  assign e_bubble  = ctrl_q.e_bubble;
  assign halted    = ctrl_q.halted;
  assign dbg_state = state_q;

`ifdef HAZ_STATS_EN
  haz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ctrl_q.f_stall),
    .count (stall_cnt)
  );

  haz_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ctrl_q.d_bubble | ctrl_q.e_bubble),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
